spi_tft_init_seq: RTL
=====================

SPI_TFT_INIT_SEQ -- requirements
Module: spi_tft_init_seq

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 16'd320, panel width in pixels in native orientation.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 16'd240, panel height in pixels in native orientation.
REQ-003 SHALL have parameter SCREEN_ORIENT, default 2'b00, rotation select; bit0=1 swaps width/height.
REQ-004 SHALL have parameter COLOR_16B, default 1, 1=RGB565 (0x55), 0=RGB666 (0x66).
REQ-005 SHALL have parameter INVERT, default 1, 1=INVON (0x21), 0=INVOFF (0x20).
REQ-006 SHALL have parameter CLK_PER_MS, default 32'd50_000, clock cycles per millisecond.
REQ-007 SHALL have parameter SHORT_DLY, default 32'd10, inter-byte gap in cycles, >=1.
REQ-008 SHALL have parameter HWRST_MS, default 8'd10; 0 skips the hardware reset phase.
REQ-009 Ports: one clock; reset is synchronous and active-high.
REQ-010 sys_clk  input  1  system clock, all logic on rising edge.
REQ-011 sys_rst  input  1  synchronous active-high reset.
REQ-012 init_req_i  input  1  start pulse or level, sampled in IDLE only.
REQ-013 init_busy_o  output  1  high from leaving IDLE until DONE inclusive.
REQ-014 init_ack_o  output  1  one-cycle pulse in DONE.
REQ-015 lcd_rst_n_o  output  1  panel hardware reset pin, active low.
REQ-016 spi_req_o  output  1  byte send request, high exactly while in SEND.
REQ-017 spi_data_o  output  8  byte to send, registered, stable throughout SEND.
REQ-018 spi_dc_o  output  1  0=command, 1=parameter, registered with spi_data_o.
REQ-019 spi_end_o  output  1  deasserts CS between bytes, high while in DELAY.
REQ-020 spi_ack_i  input  1  one-cycle pulse from SPI sender: byte done.

Function
REQ-021 States: IDLE, RST_LO, RST_HI, SEND, DELAY, DONE.
REQ-022 IDLE with init_req_i=1 -> RST_LO if HWRST_MS>0, else SEND at index 0.
REQ-023 RST_LO: lcd_rst_n_o=0 for HWRST_MS*CLK_PER_MS cycles, then RST_HI.
REQ-024 RST_HI: lcd_rst_n_o=1 for 120*CLK_PER_MS cycles, then SEND at index 0.
REQ-025 SEND: hold spi_req_o=1 until spi_ack_i=1, then DELAY next cycle.
REQ-026 DELAY: last exactly D cycles, where D is the per-entry delay, then SEND with the next index, or DONE after index 18.
REQ-027 DONE: lasts one cycle, then IDLE.
REQ-028 Table (index: dc,byte,D), where S=SHORT_DLY and M=CLK_PER_MS:
 0:0,0x01,150M. 1:0,0x11,255M. 2:0,0x3A,S. 3:1,COLOR_16B?0x55:0x66,S.
 4:0,0x36,S. 5:1,MADCTL,S. 6:0,0x2A,S. 7:1,0x00,S. 8:1,0x00,S.
 9:1,(W-1)[15:8],S. 10:1,(W-1)[7:0],S. 11:0,0x2B,S. 12:1,0x00,S. 13:1,0x00,S.
 14:1,(H-1)[15:8],S. 15:1,(H-1)[7:0],S. 16:0,INVERT?0x21:0x20,S. 17:0,0x13,10M. 18:0,0x29,255M.
REQ-029 MADCTL by SCREEN_ORIENT: 00->0x00, 01->0x60, 10->0xC0, 11->0xA0.
REQ-030 W,H: if SCREEN_ORIENT[0]=1, W=SCREEN_HEIGHT and H=SCREEN_WIDTH, else unswapped; W-1 and H-1 use full 16-bit subtraction with borrow.
REQ-031 Delay counter SHALL be 32 bits; products are computed as 32-bit constants at elaboration.
REQ-032 Index advances only on spi_ack_i sampled in SEND; spi_ack_i in any other state is ignored.
REQ-033 init_req_i outside IDLE is ignored; the sequence is never restarted mid-run.
REQ-034 A new init_req_i in IDLE after DONE reruns the full sequence from index 0.
REQ-035 spi_ack_i on the first SEND cycle is accepted, giving a minimum SEND length of 1 cycle.

Reset
REQ-036 sys_rst=1 at any time SHALL force IDLE and index 0 on the next edge.
REQ-037 During and after reset: init_busy_o=0, init_ack_o=0, spi_req_o=0, spi_end_o=0, lcd_rst_n_o=1, spi_data_o=0x00, spi_dc_o=0, counters=0.
REQ-038 Reset mid-sequence SHALL abort it; no init_ack_o is produced for the aborted run.

Verification (CLK_PER_MS=4, SHORT_DLY=2, HWRST_MS=1, sender acks 3 cycles after spi_req_o rises)
REQ-039 init_req_i pulse -> lcd_rst_n_o low 4 cycles, high 480 cycles; first SEND carries 0x01/dc0; DELAYs of 600, 1020, 2, 40 and 1020 cycles occur at indices 0, 1, 2, 17 and 18 respectively.
REQ-040 Full run, defaults otherwise -> byte stream 01 11 3A 55 36 00 2A 00 00 01 3F 2B 00 00 00 EF 21 13 29; then one init_ack_o pulse; busy drops the next cycle.
REQ-041 SCREEN_ORIENT=2'b01, 320x240 -> index 5=0x60, indices 9-10 = 00 EF, indices 14-15 = 01 3F.
REQ-042 SCREEN_WIDTH=16'd256 -> indices 9-10 = 00 FF (borrow correct); COLOR_16B=0 -> index 3=0x66; INVERT=0 -> index 16=0x20.
REQ-043 Stray spi_ack_i in DELAY and init_req_i mid-run -> index unchanged, no restart, output stream identical to REQ-040.
REQ-044 sys_rst asserted during index 7 SEND -> next cycle all outputs at reset values; new init_req_i restarts from lcd reset, index 0.

Source files
------------

// File: rtl/spi_tft_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tft_init_seq
//  Description : Power-up initialisation sequencer for an SPI TFT panel
//                (ILI9341-class command set). It drives the panel hardware
//                reset pin, waits for the panel to come out of reset, and
//                then sends a fixed 19-entry command/parameter table one byte
//                at a time through an external SPI byte sender. Each byte is
//                followed by a per-entry delay, during which chip-select is
//                released.
//
//  Ports
//    sys_clk      in   1  system clock, rising edge
//    sys_rst      in   1  synchronous active-high reset
//    init_req_i   in   1  start request, only looked at while idle
//    init_busy_o  out  1  sequence in progress (leaving idle .. done)
//    init_ack_o   out  1  one-cycle pulse when the sequence has completed
//    lcd_rst_n_o  out  1  panel hardware reset, active low
//    spi_req_o    out  1  byte send request to the SPI sender
//    spi_data_o   out  8  byte to send, stable while spi_req_o is high
//    spi_dc_o     out  1  data/command select (0 = command, 1 = parameter)
//    spi_end_o    out  1  releases chip-select between bytes
//    spi_ack_i    in   1  one-cycle pulse from the SPI sender: byte done
//
//  Revision    : 1.0  initial release
// ============================================================================
module spi_tft_init_seq #(
    parameter logic [15:0] SCREEN_WIDTH  = 16'd320,
    parameter logic [15:0] SCREEN_HEIGHT = 16'd240,
    parameter logic [1:0]  SCREEN_ORIENT = 2'b00,
    parameter int          COLOR_16B     = 1,
    parameter int          INVERT        = 1,
    parameter logic [31:0] CLK_PER_MS    = 32'd50_000,
    parameter logic [31:0] SHORT_DLY     = 32'd10,
    parameter logic [7:0]  HWRST_MS      = 8'd10
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       init_req_i,
    output logic       init_busy_o,
    output logic       init_ack_o,
    output logic       lcd_rst_n_o,
    output logic       spi_req_o,
    output logic [7:0] spi_data_o,
    output logic       spi_dc_o,
    output logic       spi_end_o,
    input  logic       spi_ack_i
);

    // ------------------------------------------------------------------------
    // Elaboration-time constants
    // ------------------------------------------------------------------------
    // Odd orientations are rotated by 90 degrees, so the addressable window
    // swaps its width and height.
    localparam logic [15:0] c_win_w   = SCREEN_ORIENT[0] ? SCREEN_HEIGHT : SCREEN_WIDTH;
    localparam logic [15:0] c_win_h   = SCREEN_ORIENT[0] ? SCREEN_WIDTH  : SCREEN_HEIGHT;
    localparam logic [15:0] c_win_w_m1 = c_win_w - 16'd1;
    localparam logic [15:0] c_win_h_m1 = c_win_h - 16'd1;

    // Memory access control: row/column exchange and mirroring per rotation.
    localparam logic [7:0] c_madctl =
        (SCREEN_ORIENT == 2'b00) ? 8'h00 :
        (SCREEN_ORIENT == 2'b01) ? 8'h60 :
        (SCREEN_ORIENT == 2'b10) ? 8'hC0 : 8'hA0;

    localparam logic [7:0] c_colmod = (COLOR_16B != 0) ? 8'h55 : 8'h66;
    localparam logic [7:0] c_invert = (INVERT != 0)    ? 8'h21 : 8'h20;

    // Delay lengths in clock cycles, all 32-bit products.
    localparam logic [31:0] c_dly_10ms  = 32'd10  * CLK_PER_MS;
    localparam logic [31:0] c_dly_120ms = 32'd120 * CLK_PER_MS;
    localparam logic [31:0] c_dly_150ms = 32'd150 * CLK_PER_MS;
    localparam logic [31:0] c_dly_255ms = 32'd255 * CLK_PER_MS;
    localparam logic [31:0] c_dly_hwrst = {24'd0, HWRST_MS} * CLK_PER_MS;

    localparam logic [4:0]  c_last_idx  = 5'd18;

    // ------------------------------------------------------------------------
    // Command table: {dc, byte} for each entry index
    // ------------------------------------------------------------------------
    function automatic logic [8:0] table_entry(input logic [4:0] idx);
        logic [8:0] e;
        e = 9'h000;
        case (idx)
            5'd0:    e = {1'b0, 8'h01};               // software reset
            5'd1:    e = {1'b0, 8'h11};               // sleep out
            5'd2:    e = {1'b0, 8'h3A};               // pixel format
            5'd3:    e = {1'b1, c_colmod};
            5'd4:    e = {1'b0, 8'h36};               // memory access control
            5'd5:    e = {1'b1, c_madctl};
            5'd6:    e = {1'b0, 8'h2A};               // column address set
            5'd7:    e = {1'b1, 8'h00};
            5'd8:    e = {1'b1, 8'h00};
            5'd9:    e = {1'b1, c_win_w_m1[15:8]};
            5'd10:   e = {1'b1, c_win_w_m1[7:0]};
            5'd11:   e = {1'b0, 8'h2B};               // page address set
            5'd12:   e = {1'b1, 8'h00};
            5'd13:   e = {1'b1, 8'h00};
            5'd14:   e = {1'b1, c_win_h_m1[15:8]};
            5'd15:   e = {1'b1, c_win_h_m1[7:0]};
            5'd16:   e = {1'b0, c_invert};            // inversion on/off
            5'd17:   e = {1'b0, 8'h13};               // normal display mode
            5'd18:   e = {1'b0, 8'h29};               // display on
            default: e = 9'h000;
        endcase
        return e;
    endfunction

    // Delay that follows each entry, in cycles.
    function automatic logic [31:0] table_delay(input logic [4:0] idx);
        logic [31:0] d;
        case (idx)
            5'd0:    d = c_dly_150ms;
            5'd1:    d = c_dly_255ms;
            5'd17:   d = c_dly_10ms;
            5'd18:   d = c_dly_255ms;
            default: d = SHORT_DLY;
        endcase
        return d;
    endfunction

    // A phase of length N is timed by loading N-1 and leaving on zero, so the
    // phase occupies exactly N cycles. A zero length still takes one cycle.
    function automatic logic [31:0] load_value(input logic [31:0] len);
        return (len == 32'd0) ? 32'd0 : (len - 32'd1);
    endfunction

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST_LO = 3'd1,
        ST_RST_HI = 3'd2,
        ST_SEND   = 3'd3,
        ST_DELAY  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [31:0] r_cnt;
    logic [4:0]  w_idx_next;
    logic [8:0]  w_entry_first;
    logic [8:0]  w_entry_next;

    assign w_idx_next    = r_idx + 5'd1;
    assign w_entry_first = table_entry(5'd0);
    assign w_entry_next  = table_entry(w_idx_next);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 5'd0;
            r_cnt       <= 32'd0;
            init_busy_o <= 1'b0;
            init_ack_o  <= 1'b0;
            lcd_rst_n_o <= 1'b1;
            spi_req_o   <= 1'b0;
            spi_data_o  <= 8'h00;
            spi_dc_o    <= 1'b0;
            spi_end_o   <= 1'b0;
        end else begin
            init_ack_o <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (init_req_i) begin
                        init_busy_o <= 1'b1;
                        r_idx       <= 5'd0;
                        if (HWRST_MS != 8'd0) begin
                            r_state     <= ST_RST_LO;
                            lcd_rst_n_o <= 1'b0;
                            r_cnt       <= load_value(c_dly_hwrst);
                        end else begin
                            r_state                <= ST_SEND;
                            spi_req_o              <= 1'b1;
                            {spi_dc_o, spi_data_o} <= w_entry_first;
                        end
                    end
                end

                ST_RST_LO: begin
                    if (r_cnt == 32'd0) begin
                        r_state     <= ST_RST_HI;
                        lcd_rst_n_o <= 1'b1;
                        r_cnt       <= load_value(c_dly_120ms);
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end

                ST_RST_HI: begin
                    if (r_cnt == 32'd0) begin
                        r_state                <= ST_SEND;
                        r_idx                  <= 5'd0;
                        spi_req_o              <= 1'b1;
                        {spi_dc_o, spi_data_o} <= w_entry_first;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end

                ST_SEND: begin
                    // The acknowledge may already arrive in the first SEND
                    // cycle; the byte outputs stay untouched until DELAY ends.
                    if (spi_ack_i) begin
                        r_state   <= ST_DELAY;
                        spi_req_o <= 1'b0;
                        spi_end_o <= 1'b1;
                        r_cnt     <= load_value(table_delay(r_idx));
                    end
                end

                ST_DELAY: begin
                    if (r_cnt == 32'd0) begin
                        spi_end_o <= 1'b0;
                        if (r_idx == c_last_idx) begin
                            r_state    <= ST_DONE;
                            r_idx      <= 5'd0;
                            init_ack_o <= 1'b1;
                        end else begin
                            r_state                <= ST_SEND;
                            r_idx                  <= w_idx_next;
                            spi_req_o              <= 1'b1;
                            {spi_dc_o, spi_data_o} <= w_entry_next;
                        end
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end

                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    init_busy_o <= 1'b0;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_idx       <= 5'd0;
                    r_cnt       <= 32'd0;
                    init_busy_o <= 1'b0;
                    lcd_rst_n_o <= 1'b1;
                    spi_req_o   <= 1'b0;
                    spi_end_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
